// File: rtl/fib_bcd_converter.sv
// Double-dabble binary-to-BCD converter, one input bit per cycle.
// Latency WIDTH cycles from accepted start to done; start is ignored while busy.
module fib_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      din,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [WIDTH-1:0]      bin_q;
    logic [WIDTH-1:0]      bin_d;
    logic [4*DIGITS-1:0]   scr_q;
    logic [4*DIGITS-1:0]   scr_d;
    logic [4*DIGITS-1:0]   scr_adj;
    logic [CW-1:0]         cnt_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  last_iter;

    // Add-3 correction on every digit >= 5, then one joint left shift.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
    end

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        bin_q   <= din;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q <= bin_d;
                    scr_q <= scr_d;
                    cnt_q <= cnt_q + CW'(1);
                    // bcd_q is only touched here so the display never sees partial digits.
                    if (last_iter) begin
                        bcd_q   <= scr_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Scoreboard bench for fib_bcd_converter: stimulus pushes expected digits and completion cycle,
// a negedge monitor pops on each rising done and also checks busy/done exclusivity and bcd stability.
module tb_fib_bcd_converter;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        start;
    logic [19:0] bcd;
    logic        busy;
    logic        done;

    typedef struct {
        logic [19:0] val;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fib_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int unsigned fib(input int n);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] v);
        din   = v;
        start = 1'b1;
        q.push_back('{to_bcd(32'(v)), cyc + 17});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    // Monitor: compares on every rising done, independent of stimulus timing.
    initial begin : monitor
        logic        prev_done;
        logic [19:0] prev_bcd;
        logic        rise;
        exp_t        e;
        prev_done = 1'b0;
        prev_bcd  = '0;
        forever begin
            @(negedge clk);
            rise = done && !prev_done;
            if (!reset) begin
                checks++;
                if (busy && done) begin
                    errors++;
                    $display("FAIL excl: busy=%0b done=%0b at cycle %0d, required not both high", busy, done, cyc);
                end
                checks++;
                if (bcd !== prev_bcd && !rise) begin
                    errors++;
                    $display("FAIL bcd_stable: bcd changed %h -> %h without completion at cycle %0d", prev_bcd, bcd, cyc);
                end
                if (rise) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done: done rose at cycle %0d with bcd=%h, no conversion expected", cyc, bcd);
                    end else begin
                        e = q.pop_front();
                        checks++;
                        if (bcd !== e.val) begin
                            errors++;
                            $display("FAIL bcd_value: got %h, required %h", bcd, e.val);
                        end
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.cyc);
                        end
                    end
                end
            end
            prev_done = done;
            prev_bcd  = bcd;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] directed [7];
        directed = '{16'd5, 16'd21, 16'd34, 16'd233, 16'd0, 16'd65535, 16'd59999};

        reset = 1'b1;
        start = 1'b0;
        din   = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b bcd=%h, required 0 0 00000", busy, done, bcd);
        end
        reset = 1'b0;
        tick();

        foreach (directed[i]) begin
            issue(directed[i]);
            wait_drain("directed");
            tick();
        end

        // start pulsed mid-conversion must be ignored
        issue(16'd1000);
        repeat (3) tick();
        din   = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_drain("start_in_shift");
        repeat (20) tick();
        checks++;
        if (done !== 1'b1 || bcd !== 20'h01000) begin
            errors++;
            $display("FAIL start_in_shift_hold: done=%b bcd=%h, required 1 01000", done, bcd);
        end

        // reset partway through a conversion
        issue(16'd4096);
        repeat (7) tick();
        reset = 1'b1;
        q.delete();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b bcd=%h, required 0 0 00000", busy, done, bcd);
        end
        reset = 1'b0;
        tick();
        issue(16'd12);
        wait_drain("after_reset");

        // back-to-back: start held high from DONE
        tick();
        issue(16'd233);
        wait_drain("b2b_first");
        din   = 16'd377;
        start = 1'b1;
        q.push_back('{to_bcd(32'd377), cyc + 17});
        repeat (8) tick();
        checks++;
        if (bcd !== 20'h00233 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: bcd=%h done=%b busy=%b, required 00233 0 1", bcd, done, busy);
        end
        repeat (8) tick();
        start = 1'b0;
        wait_drain("b2b_second");

        // upstream fibonacci result fed straight in
        tick();
        issue(16'(fib(13)));
        wait_drain("chained");

        for (int n = 0; n < 150; n++) begin
            issue(16'($urandom_range(0, 65535)));
            wait_drain("random");
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
